mem_ctrl: RTL and testbench

- Single-port byte-serial memory controller between the CPU core and the 8-bit unified RAM/IO bus.
- Arbitrates between two clients: instruction fetch (32-bit word reads) and the load/store buffer (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Serialises each access into 1-4 byte transfers and returns one-cycle completion pulses with the assembled, extended result.
- Sits directly downstream of the load/store buffer and consumes its load_store_sgn/op/addr request.

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/mem_ctrl_ext.sv | 29 ++
 rtl/mem_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: op codes,
// boolean constants, FSM state encoding and a small op classifier.
package mem_ctrl_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Load/store op codes as issued by the load/store buffer
    localparam logic [4:0] OP_LB  = 5'd0;
    localparam logic [4:0] OP_LH  = 5'd1;
    localparam logic [4:0] OP_LW  = 5'd2;
    localparam logic [4:0] OP_LBU = 5'd3;
    localparam logic [4:0] OP_LHU = 5'd4;
    localparam logic [4:0] OP_SB  = 5'd5;
    localparam logic [4:0] OP_SH  = 5'd6;
    localparam logic [4:0] OP_SW  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    function automatic logic is_store(input logic [4:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_ctrl_ext.sv
// Combinational op decoder: byte length (minus one) of an access and
// sign/zero extension of the assembled little-endian read bytes.
module mem_ctrl_ext
    import mem_ctrl_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] raw,
    output logic [1:0]  len,
    output logic [31:0] result
);

    // Length and extension per op; stores return zero
    always_comb begin
        len    = 2'd0;
        result = 32'd0;
        case (op)
            OP_LB:  begin len = 2'd0; result = {{24{raw[7]}}, raw[7:0]};   end
            OP_LBU: begin len = 2'd0; result = {24'd0, raw[7:0]};          end
            OP_LH:  begin len = 2'd1; result = {{16{raw[15]}}, raw[15:0]}; end
            OP_LHU: begin len = 2'd1; result = {16'd0, raw[15:0]};         end
            OP_LW:  begin len = 2'd3; result = raw;                        end
            OP_SB:  len = 2'd0;
            OP_SH:  len = 2'd1;
            OP_SW:  len = 2'd3;
            default: begin len = 2'd0; result = 32'd0; end
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and the
// load/store buffer onto the 8-bit RAM/IO bus, one byte per cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_MASK_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_inst,
    input  logic        ls_req,
    input  logic [4:0]  ls_op,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_data,
    output logic        ls_valid,
    output logic [31:0] ls_result
);

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n, len, len_n, cnt_inc;
    logic [4:0]  op_q, op_n;
    logic        fetch_q, fetch_n;
    logic [31:0] rbuf, rbuf_n, data_q, data_n;
    logic [31:0] mem_a_n;
    logic [7:0]  mem_dout_n;
    logic        wr_q, wr_n;
    logic        if_valid_n, ls_valid_n;
    logic [31:0] if_inst_n, ls_result_n;

    logic        io_stall, can_accept, take_ls, take_if;
    logic [4:0]  ext_op;
    logic [1:0]  ext_len;
    logic [31:0] ext_result, assembled;

    // A store into the IO region waits for room in the IO write buffer;
    // a valid still high means the client has not yet dropped its request
    assign io_stall   = is_store(ls_op) && (ls_addr[17:16] == IO_MASK_HI) && io_buffer_full;
    assign can_accept = !if_valid && !ls_valid && !rollback;
    assign take_ls    = can_accept && ls_req && !io_stall;
    assign take_if    = can_accept && if_req && !take_ls;
    assign cnt_inc    = cnt + 2'd1;

    // Decoder sees the incoming op while idle, the held op while busy
    assign ext_op = (state == ST_IDLE) ? ls_op : op_q;

    // Merge the byte on the bus this cycle into the collected bytes
    always_comb begin
        assembled = rbuf;
        assembled[{cnt, 3'b000} +: 8] = mem_din;
    end

    mem_ctrl_ext u_ext (
        .op     (ext_op),
        .raw    (assembled),
        .len    (ext_len),
        .result (ext_result)
    );

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        len_n       = len;
        op_n        = op_q;
        fetch_n     = fetch_q;
        rbuf_n      = rbuf;
        data_n      = data_q;
        mem_a_n     = mem_a;
        mem_dout_n  = mem_dout;
        wr_n        = wr_q;
        if_valid_n  = FALSE;
        ls_valid_n  = FALSE;
        if_inst_n   = if_inst;
        ls_result_n = ls_result;
        case (state)
            ST_IDLE: begin
                if (take_ls) begin
                    mem_a_n = ls_addr;
                    cnt_n   = 2'd0;
                    len_n   = ext_len;
                    op_n    = ls_op;
                    fetch_n = FALSE;
                    rbuf_n  = 32'd0;
                    if (is_store(ls_op)) begin
                        data_n     = ls_data;
                        mem_dout_n = ls_data[7:0];
                        wr_n       = TRUE;
                        state_n    = ST_WRITE;
                    end else begin
                        state_n = ST_READ;
                    end
                end else if (take_if) begin
                    mem_a_n = if_addr;
                    cnt_n   = 2'd0;
                    len_n   = 2'd3;
                    op_n    = OP_LW;
                    fetch_n = TRUE;
                    rbuf_n  = 32'd0;
                    state_n = ST_READ;
                end
            end
            ST_READ: begin
                if (rollback) begin
                    // Flushed read: drop collected bytes, no completion
                    state_n = ST_IDLE;
                end else begin
                    mem_a_n = mem_a + 32'd1;
                    if (cnt == len) begin
                        state_n = ST_IDLE;
                        if (fetch_q) begin
                            if_valid_n = TRUE;
                            if_inst_n  = assembled;
                        end else begin
                            ls_valid_n  = TRUE;
                            ls_result_n = ext_result;
                        end
                    end else begin
                        rbuf_n = assembled;
                        cnt_n  = cnt_inc;
                    end
                end
            end
            ST_WRITE: begin
                // Rollback is ignored here so a store is never left partial
                if (cnt == len) begin
                    wr_n        = FALSE;
                    ls_valid_n  = TRUE;
                    ls_result_n = 32'd0;
                    state_n     = ST_IDLE;
                end else begin
                    cnt_n      = cnt_inc;
                    mem_a_n    = mem_a + 32'd1;
                    mem_dout_n = data_q[{cnt_inc, 3'b000} +: 8];
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and output registers; everything freezes while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 2'd0;
            len       <= 2'd0;
            op_q      <= OP_LB;
            fetch_q   <= FALSE;
            rbuf      <= 32'd0;
            data_q    <= 32'd0;
            mem_a     <= 32'd0;
            mem_dout  <= 8'd0;
            wr_q      <= FALSE;
            if_valid  <= FALSE;
            ls_valid  <= FALSE;
            if_inst   <= 32'd0;
            ls_result <= 32'd0;
        end else if (rdy) begin
            state     <= state_n;
            cnt       <= cnt_n;
            len       <= len_n;
            op_q      <= op_n;
            fetch_q   <= fetch_n;
            rbuf      <= rbuf_n;
            data_q    <= data_n;
            mem_a     <= mem_a_n;
            mem_dout  <= mem_dout_n;
            wr_q      <= wr_n;
            if_valid  <= if_valid_n;
            ls_valid  <= ls_valid_n;
            if_inst   <= if_inst_n;
            ls_result <= ls_result_n;
        end
    end

    // A frozen controller must not keep writing the held byte
    assign mem_wr = wr_q && rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of single accesses plus hand-written
// sequences for fetch, arbitration, rollback, IO stall and rdy freeze.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_valid, ls_req, ls_valid;
    logic [31:0] if_addr, if_inst, ls_addr, ls_data, ls_result;
    logic [4:0]  ls_op;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]  ram [0:262143];
    logic        pre_we = 1'b0;
    logic [31:0] pre_a = '0, pre_d = '0;
    logic [31:0] wa [$];
    logic [7:0]  wd [$];
    int          wc [$];

    mem_ctrl #(.IO_MASK_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_inst(if_inst),
        .ls_req(ls_req), .ls_op(ls_op), .ls_addr(ls_addr), .ls_data(ls_data),
        .ls_valid(ls_valid), .ls_result(ls_result)
    );

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[17:0]];

    // RAM model: backdoor preload, bus writes, and a log of every bus write
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_we)
            for (int i = 0; i < 4; i++) ram[18'(pre_a + 32'(i))] <= pre_d[8*i +: 8];
        if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
            wa.push_back(mem_a);
            wd.push_back(mem_dout);
            wc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pre;
        logic [31:0] exp_res;
        int          exp_lat;
        logic [31:0] exp_mem;
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ram[18'(a + 32'(i))];
        return w;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); pre_we = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk); pre_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one load/store; lat = edges from acceptance to the valid pulse
    task automatic do_ls(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input int stall_at, output logic [31:0] res, output int lat);
        res = '0; lat = -1;
        @(negedge clk); ls_req = 1'b1; ls_op = op; ls_addr = addr; ls_data = data;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == stall_at) rdy = 1'b0;
            if (n == stall_at + 2) rdy = 1'b1;
            if (ls_valid) begin res = ls_result; lat = n - 1; break; end
        end
        ls_req = 1'b0; rdy = 1'b1;
    endtask

    task automatic do_if(input logic [31:0] addr, output logic [31:0] res, output int lat);
        res = '0; lat = -1;
        @(negedge clk); if_req = 1'b1; if_addr = addr;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (if_valid) begin res = if_inst; lat = n - 1; break; end
        end
        if_req = 1'b0;
    endtask

    initial begin
        logic [31:0] res, lsres, ifres;
        int lat, base, nls, nif, cls, cif;

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_op = OP_LB; ls_addr = '0; ls_data = '0;

        vecs[0]  = '{OP_LB,  32'h200,      32'h0,        32'h00000080, 32'hFFFFFF80, 1, 32'h00000080};
        vecs[1]  = '{OP_LBU, 32'h200,      32'h0,        32'h00000080, 32'h00000080, 1, 32'h00000080};
        vecs[2]  = '{OP_LH,  32'h210,      32'h0,        32'h00009234, 32'hFFFF9234, 2, 32'h00009234};
        vecs[3]  = '{OP_LHU, 32'h210,      32'h0,        32'h00009234, 32'h00009234, 2, 32'h00009234};
        vecs[4]  = '{OP_LH,  32'h221,      32'h0,        32'hAA7FFE55, 32'hFFFFFE55, 2, 32'hAA7FFE55};
        vecs[5]  = '{OP_LW,  32'h230,      32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 4, 32'hDEADBEEF};
        vecs[6]  = '{OP_LW,  32'hFFFFFFFE, 32'h0,        32'hA1B2C3D4, 32'hA1B2C3D4, 4, 32'hA1B2C3D4};
        vecs[7]  = '{OP_SB,  32'h240,      32'h000000AB, 32'h11111111, 32'h00000000, 1, 32'h111111AB};
        vecs[8]  = '{OP_SH,  32'h250,      32'h55667788, 32'h00000000, 32'h00000000, 2, 32'h00007788};
        vecs[9]  = '{OP_SW,  32'h260,      32'hCAFEF00D, 32'h00000000, 32'h00000000, 4, 32'hCAFEF00D};
        vecs[10] = '{OP_LB,  32'h270,      32'h0,        32'h0000007F, 32'h0000007F, 1, 32'h0000007F};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst mem_a", mem_a, 32'h0);
        check("rst mem_dout", {24'd0, mem_dout}, 32'h0);
        check("rst mem_wr", {31'd0, mem_wr}, 32'h0);
        check("rst if_valid", {31'd0, if_valid}, 32'h0);
        check("rst ls_valid", {31'd0, ls_valid}, 32'h0);
        check("rst if_inst", if_inst, 32'h0);
        check("rst ls_result", ls_result, 32'h0);
        @(negedge clk); rst = 1'b0;

        // Table of single accesses
        for (int i = 0; i < 11; i++) begin
            preload(vecs[i].addr, vecs[i].pre);
            do_ls(vecs[i].op, vecs[i].addr, vecs[i].data, 0, res, lat);
            check($sformatf("v%0d result", i), res, vecs[i].exp_res);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d memory", i), rd_word(vecs[i].addr), vecs[i].exp_mem);
        end

        // Fetch: 4-cycle latency, single-cycle pulse
        preload(32'h100, 32'h00000513);
        do_if(32'h100, res, lat);
        check("fetch inst", res, 32'h00000513);
        check("fetch latency", 32'(lat), 32'd4);
        @(posedge clk); #1;
        check("fetch pulse width", {31'd0, if_valid}, 32'h0);

        // LW with rdy low for two cycles mid-access
        idle(2);
        do_ls(OP_LW, 32'h230, 32'h0, 2, res, lat);
        check("rdy freeze result", res, 32'hDEADBEEF);
        check("rdy freeze latency", 32'(lat), 32'd6);

        // SW byte sequence on the bus
        idle(2);
        base = wa.size();
        do_ls(OP_SW, 32'h300, 32'h11223344, 0, res, lat);
        check("sw latency", 32'(lat), 32'd4);
        check("sw write count", 32'(wa.size() - base), 32'd4);
        if (wa.size() - base == 4)
            for (int i = 0; i < 4; i++) begin
                check($sformatf("sw addr %0d", i), wa[base+i], 32'h300 + 32'(i));
                check($sformatf("sw byte %0d", i), {24'd0, wd[base+i]}, 32'h11223344 >> (8*i) & 32'hFF);
                check($sformatf("sw cycle %0d", i), 32'(wc[base+i] - wc[base]), 32'(i));
            end

        // Arbitration: LH and fetch together
        idle(2);
        nls = 0; nif = 0; cls = -1; cif = -1; lsres = '0; ifres = '0;
        @(negedge clk);
        ls_req = 1'b1; ls_op = OP_LH; ls_addr = 32'h210; if_req = 1'b1; if_addr = 32'h100;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ls_valid) begin nls++; cls = n; lsres = ls_result; ls_req = 1'b0; end
            if (if_valid) begin nif++; cif = n; ifres = if_inst; if_req = 1'b0; end
        end
        ls_req = 1'b0; if_req = 1'b0;
        check("arb ls count", 32'(nls), 32'd1);
        check("arb if count", 32'(nif), 32'd1);
        check("arb ls result", lsres, 32'hFFFF9234);
        check("arb if inst", ifres, 32'h00000513);
        check("arb ls cycle", 32'(cls), 32'd3);
        check("arb if cycle", 32'(cif), 32'd9);

        // Rollback two cycles into a fetch, then an LB must start at once
        idle(2);
        nif = 0; cls = -1; lsres = '0;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h100;
        for (int n = 1; n <= 2; n++) begin
            @(posedge clk); #1;
            if (if_valid) nif++;
        end
        rollback = 1'b1;
        @(posedge clk); #1;
        if (if_valid) nif++;
        rollback = 1'b0; if_req = 1'b0;
        ls_req = 1'b1; ls_op = OP_LB; ls_addr = 32'h200;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (if_valid) nif++;
            if (ls_valid && cls < 0) begin cls = n; lsres = ls_result; ls_req = 1'b0; end
        end
        ls_req = 1'b0;
        check("rb fetch no valid", 32'(nif), 32'd0);
        check("rb then lb cycle", 32'(cls), 32'd2);
        check("rb then lb result", lsres, 32'hFFFFFF80);

        // Rollback in the middle of a SW
        preload(32'h310, 32'h0);
        base = wa.size(); nls = 0; cls = -1;
        @(negedge clk); ls_req = 1'b1; ls_op = OP_SW; ls_addr = 32'h310; ls_data = 32'h12345678;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 2) rollback = 1'b1;
            if (n == 5) rollback = 1'b0;
            if (ls_valid) begin nls++; cls = n; ls_req = 1'b0; end
        end
        ls_req = 1'b0; rollback = 1'b0;
        check("rb sw valid count", 32'(nls), 32'd1);
        check("rb sw valid cycle", 32'(cls), 32'd5);
        check("rb sw writes", 32'(wa.size() - base), 32'd4);
        check("rb sw memory", rd_word(32'h310), 32'h12345678);

        // IO store stalls while the IO buffer is full
        idle(2);
        io_buffer_full = 1'b1;
        base = wa.size(); nls = 0;
        @(negedge clk); ls_req = 1'b1; ls_op = OP_SB; ls_addr = 32'h30000; ls_data = 32'h0000005A;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
            if (ls_valid) nls++;
        end
        check("io stall writes", 32'(wa.size() - base), 32'd0);
        check("io stall valid", 32'(nls), 32'd0);
        io_buffer_full = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ls_valid) begin nls++; ls_req = 1'b0; end
        end
        ls_req = 1'b0;
        check("io release valid", 32'(nls), 32'd1);
        check("io release writes", 32'(wa.size() - base), 32'd1);
        if (wa.size() > base) begin
            check("io write addr", wa[base], 32'h30000);
            check("io write byte", {24'd0, wd[base]}, 32'h5A);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
